// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM stage: one-hot load-type bit positions,
// lane widths, DM base address and the MEM/WB register layout.
package mem_wb_stage_pkg;

  localparam int LT_W     = 5;
  localparam int BYTEEN_W = 4;

  // One-hot loadType bit positions
  localparam int LT_LW  = 0;
  localparam int LT_LH  = 1;
  localparam int LT_LHU = 2;
  localparam int LT_LB  = 3;
  localparam int LT_LBU = 4;

  localparam logic [31:0] DM_BASE = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        rfwr;
    logic [4:0]  a3;
    logic [2:0]  tnew;
    logic [31:0] data;
  } mwb_t;

  // Remaining-cycle count one stage later; holds at 0 instead of wrapping.
  function automatic logic [2:0] tnew_dec(input logic [2:0] t);
    return (t == 3'd0) ? 3'd0 : t - 3'd1;
  endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// EX/MEM inputs, W-stage forward source and MEM/WB outputs of the MEM stage.
interface mem_wb_stage_if;
  import mem_wb_stage_pkg::*;

  logic [31:0]         E_pc;
  logic [31:0]         E_instr;
  logic                E_RFWR;
  logic [4:0]          E_A3;
  logic [2:0]          E_tnew;
  logic [31:0]         E_data;
  logic [31:0]         E_RD2;
  logic [BYTEEN_W-1:0] E_byteen;
  logic [LT_W-1:0]     E_loadType;
  logic                E_about_DM;
  logic                W_RFWR;
  logic [4:0]          W_A3;
  logic [31:0]         W_data;
  logic [31:0]         M_pc;
  logic [31:0]         M_instr;
  logic                M_RFWR;
  logic [4:0]          M_A3;
  logic [2:0]          M_tnew;
  logic [31:0]         M_data;

  modport master (
    output E_pc, E_instr, E_RFWR, E_A3, E_tnew, E_data, E_RD2, E_byteen,
           E_loadType, E_about_DM, W_RFWR, W_A3, W_data,
    input  M_pc, M_instr, M_RFWR, M_A3, M_tnew, M_data
  );

  modport slave (
    input  E_pc, E_instr, E_RFWR, E_A3, E_tnew, E_data, E_RD2, E_byteen,
           E_loadType, E_about_DM, W_RFWR, W_A3, W_data,
    output M_pc, M_instr, M_RFWR, M_A3, M_tnew, M_data
  );

endinterface

// File: rtl/mem_wb_stage_dm_ext.sv
// Load extractor: picks the addressed byte/halfword out of a DM word and
// sign- or zero-extends it. Lowest set loadType bit wins if several are set.
module mem_wb_stage_dm_ext
  import mem_wb_stage_pkg::*;
(
  input  logic [31:0]     word,
  input  logic [1:0]      off,
  input  logic [LT_W-1:0] load_type,
  output logic [31:0]     ext
);

  logic [15:0] half;
  logic [7:0]  bsel;

  // Lane select then priority-ordered extension
  always_comb begin
    half = off[1] ? word[31:16] : word[15:0];
    case (off)
      2'd0:    bsel = word[7:0];
      2'd1:    bsel = word[15:8];
      2'd2:    bsel = word[23:16];
      default: bsel = word[31:24];
    endcase
    ext = '0;
    if      (load_type[LT_LW])  ext = word;
    else if (load_type[LT_LH])  ext = {{16{half[15]}}, half};
    else if (load_type[LT_LHU]) ext = {16'h0, half};
    else if (load_type[LT_LB])  ext = {{24{bsel[7]}}, bsel};
    else if (load_type[LT_LBU]) ext = {24'h0, bsel};
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage of the P6 MIPS core: byte-enabled data memory, store-data
// forwarding from W, load extension and the MEM/WB register.
// Optional macro DM_TRACE_EN prints one line per performed store.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DM_WORDS = 3072,
  parameter int IDX_W    = 12
) (
  input logic          clk,
  input logic          reset,
  mem_wb_stage_if.slave bus
);

  logic [BYTEEN_W-1:0][7:0] dm [DM_WORDS];

  logic [31:0]              rel;
  logic [1:0]               off;
  logic [IDX_W-1:0]         idx;
  logic                     in_range;
  logic [4:0]               rt;
  logic                     fwd;
  logic [BYTEEN_W-1:0][7:0] wd_l;
  logic [BYTEEN_W-1:0][7:0] rd_l;
  logic [BYTEEN_W-1:0][7:0] mrg_l;
  logic                     st_en;
  logic                     ld_sel;
  logic [31:0]              ld_ext;
  mwb_t                     m_d;
  mwb_t                     m_q;

  assign rel      = bus.E_data - DM_BASE;
  assign off      = rel[1:0];
  assign idx      = rel[IDX_W+1:2];
  assign in_range = rel < 32'(4 * DM_WORDS);
  assign rt       = bus.E_instr[20:16];

  // Store data: take the W-stage result when it targets rt, realigned to the lane
  always_comb begin
    fwd  = bus.W_RFWR && (bus.W_A3 == rt) && (bus.W_A3 != 5'd0) && (bus.E_byteen != '0);
    wd_l = fwd ? (bus.W_data << {off, 3'b000}) : bus.E_RD2;
    rd_l = in_range ? dm[idx] : '0;
  end

  // Per-lane merge of new store bytes over the current word
  for (genvar i = 0; i < BYTEEN_W; i++) begin : g_lane
    assign mrg_l[i] = bus.E_byteen[i] ? wd_l[i] : rd_l[i];
  end

  assign st_en  = bus.E_about_DM && (bus.E_byteen != '0) && in_range;
  assign ld_sel = bus.E_about_DM && (bus.E_loadType != '0);

  mem_wb_stage_dm_ext u_ext (
    .word      (rd_l),
    .off       (off),
    .load_type (bus.E_loadType),
    .ext       (ld_ext)
  );

  // Data memory: reset clears every word and wins over a same-cycle store
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DM_WORDS; i++) dm[i] <= '0;
    end else if (st_en) begin
      dm[idx] <= mrg_l;
    end
  end

`ifdef DM_TRACE_EN
  // Store trace, only for stores that actually land
  always_ff @(posedge clk) begin
    if (!reset && st_en)
      $display("@%h: *%h <= %h", bus.E_pc, {bus.E_data[31:2], 2'b00}, mrg_l);
  end
`else
`endif

  // Next MEM/WB register contents
  always_comb begin
    m_d.pc    = bus.E_pc;
    m_d.instr = bus.E_instr;
    m_d.rfwr  = bus.E_RFWR;
    m_d.a3    = bus.E_A3;
    m_d.tnew  = tnew_dec(bus.E_tnew);
    m_d.data  = ld_sel ? ld_ext : bus.E_data;
  end

  // MEM/WB register, updates every cycle
  always_ff @(posedge clk) begin
    if (reset) m_q <= '0;
    else       m_q <= m_d;
  end

  assign bus.M_pc    = m_q.pc;
  assign bus.M_instr = m_q.instr;
  assign bus.M_RFWR  = m_q.rfwr;
  assign bus.M_A3    = m_q.a3;
  assign bus.M_tnew  = m_q.tnew;
  assign bus.M_data  = m_q.data;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: vector table plus a few hand sequences.
module tb_mem_wb_stage;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_wb_stage_if bus();

  mem_wb_stage #(.DM_WORDS(3072), .IDX_W(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       nm;
    logic        rst;
    logic [31:0] data;
    logic [31:0] rd2;
    logic [3:0]  be;
    logic [4:0]  lt;
    logic        dm;
    logic [4:0]  rt;
    logic [2:0]  tnew;
    logic        wrf;
    logic [4:0]  wa3;
    logic [31:0] wd;
    logic [31:0] exp_data;
    logic [2:0]  exp_tnew;
  } vec_t;

  int applied = 0;
  int miscmp  = 0;
  vec_t tbl[$];

  function automatic vec_t mk(string nm, logic rst, logic [31:0] data, logic [31:0] rd2,
                              logic [3:0] be, logic [4:0] lt, logic dm, logic [4:0] rt,
                              logic [2:0] tnew, logic wrf, logic [4:0] wa3, logic [31:0] wd,
                              logic [31:0] exp_data, logic [2:0] exp_tnew);
    vec_t v;
    v.nm = nm; v.rst = rst; v.data = data; v.rd2 = rd2; v.be = be; v.lt = lt;
    v.dm = dm; v.rt = rt; v.tnew = tnew; v.wrf = wrf; v.wa3 = wa3; v.wd = wd;
    v.exp_data = exp_data; v.exp_tnew = exp_tnew;
    return v;
  endfunction

  // Drive one vector for one cycle, then check every M_* output after the edge.
  task automatic apply(input vec_t v, input logic [31:0] pc);
    logic [31:0]  instr;
    logic         rf;
    logic [4:0]   a3;
    logic [104:0] act;
    logic [104:0] exp;
    instr = {11'd0, v.rt, 16'h0000};
    rf    = (v.be == 4'd0);
    a3    = rf ? 5'd8 : 5'd0;
    @(negedge clk);
    reset          = v.rst;
    bus.E_pc       = pc;
    bus.E_instr    = instr;
    bus.E_RFWR     = rf;
    bus.E_A3       = a3;
    bus.E_tnew     = v.tnew;
    bus.E_data     = v.data;
    bus.E_RD2      = v.rd2;
    bus.E_byteen   = v.be;
    bus.E_loadType = v.lt;
    bus.E_about_DM = v.dm;
    bus.W_RFWR     = v.wrf;
    bus.W_A3       = v.wa3;
    bus.W_data     = v.wd;
    @(posedge clk);
    #1;
    act = {bus.M_pc, bus.M_instr, bus.M_RFWR, bus.M_A3, bus.M_tnew, bus.M_data};
    exp = v.rst ? '0 : {pc, instr, rf, a3, v.exp_tnew, v.exp_data};
    applied++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got pc=%h instr=%h rfwr=%b a3=%0d tnew=%0d data=%h, want pc=%h instr=%h rfwr=%b a3=%0d tnew=%0d data=%h",
               v.nm, act[104:73], act[72:41], act[40], act[39:35], act[34:32], act[31:0],
               exp[104:73], exp[72:41], exp[40], exp[39:35], exp[34:32], exp[31:0]);
    end
  endtask

  localparam logic [4:0] LW = 5'b00001, LH = 5'b00010, LHU = 5'b00100,
                         LB = 5'b01000, LBU = 5'b10000, ST = 5'b00000;

  initial begin
    bus.E_pc = '0; bus.E_instr = '0; bus.E_RFWR = 0; bus.E_A3 = '0; bus.E_tnew = '0;
    bus.E_data = '0; bus.E_RD2 = '0; bus.E_byteen = '0; bus.E_loadType = '0;
    bus.E_about_DM = 0; bus.W_RFWR = 0; bus.W_A3 = '0; bus.W_data = '0;

    //          name        rst data          rd2           be       lt   dm rt  tnew wrf wa3 wd          exp_data      exp_tnew
    tbl.push_back(mk("rst0",      1, 32'h10,  32'h0,        4'b0000, LW,  1, 0,  2, 0, 0, 0,          32'h0,        0));
    tbl.push_back(mk("rst1",      1, 32'h10,  32'h0,        4'b0000, LW,  1, 0,  2, 0, 0, 0,          32'h0,        0));
    tbl.push_back(mk("lw_clr",    0, 32'h10,  32'h0,        4'b0000, LW,  1, 0,  2, 0, 0, 0,          32'h0,        1));
    tbl.push_back(mk("sw_20",     0, 32'h20,  32'h8899AABB, 4'b1111, ST,  1, 4,  0, 0, 0, 0,          32'h20,       0));
    tbl.push_back(mk("lb_21",     0, 32'h21,  32'h0,        4'b0000, LB,  1, 0,  0, 0, 0, 0,          32'hFFFFFFAA, 0));
    tbl.push_back(mk("lbu_21",    0, 32'h21,  32'h0,        4'b0000, LBU, 1, 0,  0, 0, 0, 0,          32'h000000AA, 0));
    tbl.push_back(mk("lh_22",     0, 32'h22,  32'h0,        4'b0000, LH,  1, 0,  0, 0, 0, 0,          32'hFFFF8899, 0));
    tbl.push_back(mk("lhu_20",    0, 32'h20,  32'h0,        4'b0000, LHU, 1, 0,  0, 0, 0, 0,          32'h0000AABB, 0));
    tbl.push_back(mk("sb_23",     0, 32'h23,  32'h11000000, 4'b1000, ST,  1, 4,  0, 0, 0, 0,          32'h23,       0));
    tbl.push_back(mk("lw_20_sb",  0, 32'h20,  32'h0,        4'b0000, LW,  1, 0,  0, 0, 0, 0,          32'h1199AABB, 0));
    tbl.push_back(mk("lt_multi",  0, 32'h20,  32'h0,        4'b0000, 5'b01010, 1, 0, 0, 0, 0, 0,     32'hFFFFAABB, 0));
    tbl.push_back(mk("lt_nodm",   0, 32'h20,  32'h0,        4'b0000, LW,  0, 0,  0, 0, 0, 0,          32'h20,       0));
    tbl.push_back(mk("sh_fwd",    0, 32'h42,  32'h0,        4'b1100, ST,  1, 5,  0, 1, 5, 32'h1234,   32'h42,       0));
    tbl.push_back(mk("lw_40_fwd", 0, 32'h40,  32'h0,        4'b0000, LW,  1, 0,  0, 0, 0, 0,          32'h12340000, 0));
    tbl.push_back(mk("sh_r0",     0, 32'h42,  32'h0,        4'b1100, ST,  1, 0,  0, 1, 0, 32'h1234,   32'h42,       0));
    tbl.push_back(mk("lw_40_r0",  0, 32'h40,  32'h0,        4'b0000, LW,  1, 0,  0, 0, 0, 0,          32'h0,        0));
    tbl.push_back(mk("alu_t2",    0, 32'hDEADBEEF, 32'h0,   4'b0000, ST,  0, 0,  2, 0, 0, 0,          32'hDEADBEEF, 1));
    tbl.push_back(mk("alu_t0",    0, 32'h00C0FFEE, 32'h0,   4'b0000, ST,  0, 0,  0, 0, 0, 0,          32'h00C0FFEE, 0));
    tbl.push_back(mk("alu_t7",    0, 32'h1,   32'h0,        4'b0000, ST,  0, 0,  7, 0, 0, 0,          32'h1,        6));
    tbl.push_back(mk("sw_oor",    0, 32'h3000, 32'hCAFEF00D, 4'b1111, ST, 1, 4,  0, 0, 0, 0,          32'h3000,     0));
    tbl.push_back(mk("lw_oor",    0, 32'h3000, 32'h0,       4'b0000, LW,  1, 0,  0, 0, 0, 0,          32'h0,        0));
    tbl.push_back(mk("lw_0_pre",  0, 32'h0,   32'h0,        4'b0000, LW,  1, 0,  0, 0, 0, 0,          32'h0,        0));
    tbl.push_back(mk("lw_2ffc",   0, 32'h2FFC, 32'h0,       4'b0000, LW,  1, 0,  0, 0, 0, 0,          32'h0,        0));
    tbl.push_back(mk("sw_rst",    1, 32'h0,   32'h55555555, 4'b1111, ST,  1, 4,  0, 0, 0, 0,          32'h0,        0));
    tbl.push_back(mk("lw_0_rst",  0, 32'h0,   32'h0,        4'b0000, LW,  1, 0,  0, 0, 0, 0,          32'h0,        0));
    tbl.push_back(mk("lw_20_rst", 0, 32'h20,  32'h0,        4'b0000, LW,  1, 0,  0, 0, 0, 0,          32'h0,        0));

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i], 32'h0000_3000 + 32'(4 * i));

    // Back-to-back byte stores to each lane of one word, then read it whole
    for (int i = 0; i < 4; i++)
      apply(mk("sb_lane", 0, 32'h80 + 32'(i), 32'(8'h11 * (i + 1)) << (8 * i), 4'b0001 << i,
               ST, 1, 4, 0, 0, 0, 0, 32'h80 + 32'(i), 0), 32'h4000 + 32'(4 * i));
    apply(mk("lw_80_lanes", 0, 32'h80, 32'h0, 4'b0000, LW, 1, 0, 0, 0, 0, 0, 32'h44332211, 0), 32'h4010);

    // W-stage destination differs from rt: stored data comes from E_RD2
    apply(mk("sw_nofwd", 0, 32'h84, 32'hA5A5A5A5, 4'b1111, ST, 1, 5, 0, 1, 6, 32'h1, 32'h84, 0), 32'h4014);
    apply(mk("lw_84",    0, 32'h84, 32'h0, 4'b0000, LW, 1, 0, 0, 0, 0, 0, 32'hA5A5A5A5, 0), 32'h4018);

    // Full-word forward overrides stale E_RD2; byte load from the forwarded word
    apply(mk("sw_fwd",   0, 32'h88, 32'hFFFFFFFF, 4'b1111, ST, 1, 9, 0, 1, 9, 32'h0BADF00D, 32'h88, 0), 32'h401C);
    apply(mk("lw_88",    0, 32'h88, 32'h0, 4'b0000, LW, 1, 0, 0, 0, 0, 0, 32'h0BADF00D, 0), 32'h4020);
    apply(mk("lbu_8b",   0, 32'h8B, 32'h0, 4'b0000, LBU, 1, 0, 0, 0, 0, 0, 32'h0000000B, 0), 32'h4024);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscmp);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM pipeline stage of the P6 MIPS core: the consumer of the EX/MEM register outputs.
- Owns the byte-enabled data memory and performs stores using the lane-aligned store data and byteen produced upstream.
- Extracts and extends load data according to the one-hot loadType, then registers results into the MEM/WB register.
- Drives M_RFWR/M_A3/M_data back to the EX stage for forwarding, and forwards W-stage results into store data.

Parameters:
- DM_WORDS, 3072, data memory depth in 32-bit words (byte range 0x0000 to 4*DM_WORDS-1).
- IDX_W, 12, word-index width; index is addr[IDX_W+1:2].

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- E_pc  in  32  instruction PC from EX/MEM
- E_instr  in  32  instruction word; rt = E_instr[20:16]
- E_RFWR  in  1  register-write enable
- E_A3  in  5  destination register
- E_tnew  in  3  remaining cycles until result is ready
- E_data  in  32  ALU result: memory byte address for DM instructions, writeback value otherwise
- E_RD2  in  32  store data, already shifted left by {addr[1:0],3'b0}
- E_byteen  in  4  store byte lanes; 0 = no store
- E_loadType  in  5  one-hot: [0] lw, [1] lh, [2] lhu, [3] lb, [4] lbu; 0 = not a load
- E_about_DM  in  1  instruction accesses DM
- W_RFWR  in  1  W-stage write enable (forward source)
- W_A3  in  5  W-stage destination
- W_data  in  32  W-stage writeback value
- M_pc, M_instr  out  32  registered copies of E_pc / E_instr
- M_RFWR  out  1  registered E_RFWR
- M_A3  out  5  registered E_A3
- M_tnew  out  3  registered, decremented tnew
- M_data  out  32  registered writeback value (load result or E_data)

Behaviour:
- Reset: at posedge with reset=1, every output register goes to 0 and all DM words are cleared to 0. A reset asserted in the same cycle as a store takes priority; the store is dropped.
- Address and lanes: addr = E_data, off = addr[1:0], idx = addr[IDX_W+1:2]. in_range = (addr < 4*DM_WORDS).
- Store-data forwarding: if W_RFWR, W_A3 == rt, W_A3 != 0 and E_byteen != 0, then wd = W_data << {off,3'b0}. Otherwise wd = E_RD2.
- Store: at posedge when !reset, E_about_DM, E_byteen != 0 and in_range, each DM byte lane i with E_byteen[i]=1 takes wd[8i+7:8i]. Other lanes are preserved. An out-of-range store is ignored.
- Load read: combinational read of word = DM[idx]; word = 0 if !in_range.
  - lw: word.
  - lh: sign-extend word[16*off[1]+15 : 16*off[1]].
  - lhu: the same halfword, zero-extended.
  - lb: sign-extend byte off.
  - lbu: byte off, zero-extended.
  - More than one loadType bit set is illegal; the lowest set bit wins.
- Writeback select: if E_about_DM and E_loadType != 0, next M_data = load result. Otherwise next M_data = E_data (stores and ALU ops pass through).
- Latency: exactly 1 cycle from E_* to M_*. No stall or flush inputs; the register updates every cycle.
- tnew: M_tnew <= (E_tnew == 0) ? 0 : E_tnew - 1. It saturates at 0 and never wraps.
- Read-after-write: a load in the cycle immediately after a store to the same word sees the new data, because the write lands at the edge.
- Stores: M_RFWR passes through unchanged. Upstream guarantees it is 0 for stores; this block does not mask it.

Optional Feature:
- Macro DM_TRACE_EN.
- Defined: on every performed store, print once at that clock edge "@<E_pc hex>: *<addr with low 2 bits cleared, hex> <= <merged 32-bit word hex>".
- Defined: out-of-range and reset-dropped stores print nothing.
- Not defined: no display statements are compiled; functionality is identical.

Decomposition:
- Shared package/header (onehot include):
  - loadType bit positions LT_LW..LT_LBU.
  - LT_W = 5, BYTEEN_W = 4.
  - DM base address 0x0000.
- Sub-module dm_ext: purely combinational word-plus-offset-plus-loadType to 32-bit extended result. It is instantiated once here.

Test Plan:
- Reset: reset for 2 cycles, then lw addr 0x10 -> M_data=0. All M_* are 0 during reset.
- sw + load mix: sw 0x8899AABB to 0x20 (byteen=1111), then:
  - lb 0x21 -> 0xFFFFFFAA
  - lbu 0x21 -> 0x000000AA
  - lh 0x22 -> 0xFFFF8899
  - lhu 0x20 -> 0x0000AABB
- sb lanes: after the word above, sb 0x11 to 0x23 (byteen=1000, E_RD2=0x11000000), then lw 0x20 -> 0x1199AABB.
- Store-data forwarding: sh, rt=$5, addr 0x42, E_RD2 stale 0, with W_RFWR=1, W_A3=5, W_data=0x1234 -> lw 0x40 returns 0x12340000. Repeat with W_A3=0 -> 0x00000000.
- Pass-through and tnew: ALU op with E_data=0xDEADBEEF, E_tnew=2 -> M_data=0xDEADBEEF, M_tnew=1. E_tnew=0 -> M_tnew=0.
- Out of range and reset priority:
  - sw to 0x3000 is ignored; lw 0x3000 -> 0.
  - sw to 0x0 asserted together with reset -> lw 0x0 returns 0.
  - With DM_TRACE_EN: exactly one trace line for the 0x20 sw.
